dmem_copy_engine: RTL and testbench

- Initiator-side master for the data memory: drives write-enable, address and write data, and consumes the asynchronous read data.
- Copies a block of 32-bit words from a source word-index range to a destination word-index range in the same memory.
- Used to initialise or move data-memory regions, e.g. preloading test vectors or relocating arrays, while the core is held off the memory port by a higher-level mux.

---
 rtl/dmem_copy_engine.sv | 158 +++++++++++++++
 tb/tb_dmem_copy_engine.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine
// Copies a block of words inside the data memory, from an ascending source
// word-index range to an ascending destination range. Each word takes two
// cycles: a READ cycle that presents the source address and captures the
// asynchronous read data, then a WRITE cycle that stores it at the
// destination. The write lands on the rising edge that ends the WRITE cycle.
//
// Ports:
//   i_clk             system clock, rising edge
//   i_arst_n          asynchronous active-low reset
//   i_start           copy request, sampled only while idle
//   i_src_addr        first source word index
//   i_dst_addr        first destination word index
//   i_length          number of words to copy
//   o_busy            high whenever the engine is not idle
//   o_done            one-cycle completion pulse
//   o_error           last accepted request violated the memory range
//   o_words_copied    words written by the current or last transfer
//   o_mem_we          memory write enable (only in WRITE)
//   o_mem_address     memory word address (0 outside READ/WRITE)
//   o_mem_write_data  memory write data (0 outside WRITE)
//   i_mem_read_data   asynchronous memory read data
module dmem_copy_engine #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int CELLS_NUMBER = 128,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [LEN_WIDTH-1:0]  o_words_copied,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] CELLS_EXT = (ADDR_WIDTH+1)'(CELLS_NUMBER);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] src_ptr_reg, src_ptr_next;
  logic [ADDR_WIDTH-1:0] dst_ptr_reg, dst_ptr_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  count_reg, count_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  error_reg, error_next;

  // End-of-range sums carry one extra bit so a huge index plus a length
  // cannot wrap around and masquerade as an in-range request.
  logic [ADDR_WIDTH:0]   src_end;
  logic [ADDR_WIDTH:0]   dst_end;
  logic                  range_bad;
  logic [LEN_WIDTH-1:0]  count_inc;

  assign src_end   = {1'b0, i_src_addr} + (ADDR_WIDTH+1)'(i_length);
  assign dst_end   = {1'b0, i_dst_addr} + (ADDR_WIDTH+1)'(i_length);
  assign range_bad = (src_end > CELLS_EXT) || (dst_end > CELLS_EXT);
  assign count_inc = count_reg + LEN_WIDTH'(1);

  // State and datapath registers. Reset is asynchronous so the write enable,
  // which decodes straight from the state, drops the moment reset asserts.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_reg   <= ST_IDLE;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      len_reg     <= '0;
      count_reg   <= '0;
      data_reg    <= '0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      src_ptr_reg <= src_ptr_next;
      dst_ptr_reg <= dst_ptr_next;
      len_reg     <= len_next;
      count_reg   <= count_next;
      data_reg    <= data_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    src_ptr_next     = src_ptr_reg;
    dst_ptr_next     = dst_ptr_reg;
    len_next         = len_reg;
    count_next       = count_reg;
    data_next        = data_reg;
    error_next       = error_reg;
    o_busy           = (state_reg != ST_IDLE);
    o_done           = 1'b0;
    o_mem_we         = 1'b0;
    o_mem_address    = '0;
    o_mem_write_data = '0;

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          src_ptr_next = i_src_addr;
          dst_ptr_next = i_dst_addr;
          len_next     = i_length;
          count_next   = '0;
          error_next   = range_bad;
          if (range_bad || (i_length == '0)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        o_mem_address = src_ptr_reg;
        data_next     = i_mem_read_data;
        state_next    = ST_WRITE;
      end
      ST_WRITE: begin
        o_mem_we         = 1'b1;
        o_mem_address    = dst_ptr_reg;
        o_mem_write_data = data_reg;
        src_ptr_next     = src_ptr_reg + ADDR_WIDTH'(1);
        dst_ptr_next     = dst_ptr_reg + ADDR_WIDTH'(1);
        count_next       = count_inc;
        // Ascending word-by-word copy: with an overlapping dst > src the
        // engine re-reads words it has already written.
        if (count_inc == len_reg) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_READ;
        end
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_error        = error_reg;
  assign o_words_copied = count_reg;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine
// Bench for dmem_copy_engine. Holds a 128-word asynchronous-read memory, a
// reference memory image and a queue of expected per-cycle outputs that is
// built from the copy rules when a request is accepted. A negedge process
// compares every DUT output against that queue each cycle; directed tests add
// hand-computed literal expectations.
module tb_dmem_copy_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CN = 128;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic          we;
    logic [LW-1:0] words;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_arst_n;
  logic          i_start;
  logic [AW-1:0] i_src_addr;
  logic [AW-1:0] i_dst_addr;
  logic [LW-1:0] i_length;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [LW-1:0] o_words_copied;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_address;
  logic [DW-1:0] o_mem_write_data;
  logic [DW-1:0] i_mem_read_data;

  always #5 i_clk = ~i_clk;

  dmem_copy_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELLS_NUMBER(CN), .LEN_WIDTH(LW)
  ) dut (
    .i_clk(i_clk),
    .i_arst_n(i_arst_n),
    .i_start(i_start),
    .i_src_addr(i_src_addr),
    .i_dst_addr(i_dst_addr),
    .i_length(i_length),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error),
    .o_words_copied(o_words_copied),
    .o_mem_we(o_mem_we),
    .o_mem_address(o_mem_address),
    .o_mem_write_data(o_mem_write_data),
    .i_mem_read_data(i_mem_read_data)
  );

  logic [DW-1:0] mem     [CN];
  logic [DW-1:0] ref_mem [CN];
  bit            mem_init_done = 1'b0;
  logic          pre_we;
  logic [6:0]    pre_addr;
  logic [DW-1:0] pre_data;

  exp_t exp_q[$];
  int   rd_idx = 0;
  bit   last_was_idle = 1'b1;
  exp_t last_cmp = '0;
  int   cmp_seq = 0;
  int   commit_seq = 0;
  logic          held_err = 1'b0;
  logic [LW-1:0] held_words = '0;

  int cmp_checks = 0;
  int cmp_fails  = 0;
  int lit_checks = 0;
  int lit_fails  = 0;

  always_comb begin
    i_mem_read_data = '0;
    if (o_mem_address < 32'(CN)) i_mem_read_data = mem[o_mem_address[6:0]];
  end

  // Builds the expected per-cycle outputs of one accepted request from the
  // copy rules: two cycles per word in ascending order, then a done cycle.
  task automatic model_accept(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                              input logic [LW-1:0] len);
    logic [DW-1:0] scratch [CN];
    exp_t e;
    int s, d;
    for (int i = 0; i < CN; i++) scratch[i] = ref_mem[i];
    if (longint'(src) + longint'(len) > CN || longint'(dst) + longint'(len) > CN) begin
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
    end else begin
      s = int'(src);
      d = int'(dst);
      for (int k = 0; k < int'(len); k++) begin
        e = '0; e.busy = 1'b1; e.words = LW'(k); e.addr = AW'(s + k);
        exp_q.push_back(e);
        e.we = 1'b1; e.addr = AW'(d + k); e.wdata = scratch[s + k];
        exp_q.push_back(e);
        scratch[d + k] = e.wdata;
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.words = len;
      exp_q.push_back(e);
    end
  endtask

  // Memory, reference-image commits and request acceptance.
  always @(posedge i_clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < CN; i++) begin
        mem[i]     <= 32'hC0DE_0000 | 32'(i);
        ref_mem[i] <= 32'hC0DE_0000 | 32'(i);
      end
      mem_init_done <= 1'b1;
    end else begin
      if (pre_we) begin
        mem[pre_addr]     <= pre_data;
        ref_mem[pre_addr] <= pre_data;
      end
      if (o_mem_we && o_mem_address < 32'(CN)) mem[o_mem_address[6:0]] <= o_mem_write_data;
      if (i_arst_n && cmp_seq != commit_seq) begin
        if (last_cmp.we) ref_mem[last_cmp.addr[6:0]] <= last_cmp.wdata;
        commit_seq <= cmp_seq;
      end
      if (i_arst_n && i_start && rd_idx == exp_q.size() && last_was_idle)
        model_accept(i_src_addr, i_dst_addr, i_length);
    end
  end

  // Per-cycle comparison of every output against the expected queue.
  always @(negedge i_clk) begin
    exp_t e;
    exp_t act;
    if (!i_arst_n) begin
      rd_idx        <= exp_q.size();
      last_was_idle <= 1'b1;
      held_err      <= 1'b0;
      held_words    <= '0;
      last_cmp      <= '0;
    end else begin
      if (rd_idx < exp_q.size()) begin
        e = exp_q[rd_idx];
        rd_idx        <= rd_idx + 1;
        last_was_idle <= 1'b0;
        if (e.done) begin
          held_err   <= e.err;
          held_words <= e.words;
        end
      end else begin
        e = '0;
        e.err   = held_err;
        e.words = held_words;
        last_was_idle <= 1'b1;
      end
      act = {o_busy, o_done, o_error, o_mem_we, o_words_copied, o_mem_address, o_mem_write_data};
      cmp_checks <= cmp_checks + 1;
      if (act !== e) begin
        cmp_fails <= cmp_fails + 1;
        $display("FAIL cycle_outputs t=%0t actual busy=%b done=%b err=%b we=%b words=%0d addr=%0h wdata=%0h required busy=%b done=%b err=%b we=%b words=%0d addr=%0h wdata=%0h",
                 $time, act.busy, act.done, act.err, act.we, act.words, act.addr, act.wdata,
                 e.busy, e.done, e.err, e.we, e.words, e.addr, e.wdata);
      end
      last_cmp <= e;
      cmp_seq  <= cmp_seq + 1;
    end
  end

  task automatic lit(input string name, input logic [79:0] act, input logic [79:0] req);
    lit_checks++;
    if (act !== req) begin
      lit_fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  function automatic logic [79:0] all_outputs();
    return 80'({o_busy, o_done, o_error, o_mem_we, o_words_copied, o_mem_address, o_mem_write_data});
  endfunction

  task automatic preload(input int base, input logic [DW-1:0] vals [$]);
    foreach (vals[i]) begin
      @(negedge i_clk); #1;
      pre_we = 1'b1; pre_addr = 7'(base + i); pre_data = vals[i];
    end
    @(negedge i_clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic start_req(input int src, input int dst, input int len);
    @(negedge i_clk); #1;
    i_start = 1'b1; i_src_addr = AW'(src); i_dst_addr = AW'(dst); i_length = LW'(len);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    $display("start src=%0d dst=%0d len=%0d", src, dst, len);
  endtask

  // Called just after the start edge; cycle 1 is the cycle after that edge.
  task automatic wait_done(output int cyc, output int wes, output bit consec, output logic first_err);
    bit prev_we = 1'b0;
    cyc = 0; wes = 0; consec = 1'b0; first_err = 1'bx;
    for (int n = 1; n <= 60; n++) begin
      @(negedge i_clk);
      if (n == 1) first_err = o_error;
      if (o_mem_we) begin
        wes++;
        if (prev_we) consec = 1'b1;
      end
      prev_we = o_mem_we;
      if (o_done) begin
        cyc = n;
        break;
      end
    end
    if (cyc == 0) lit("done_timeout", 80'(0), 80'(1));
  endtask

  task automatic image_check(input string name);
    int bad = -1;
    for (int i = 0; i < CN; i++)
      if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
    lit(name, 80'((bad < 0) ? 0 : bad + 1), 80'(0));
  endtask

  initial begin
    int cyc, wes;
    bit consec;
    logic ferr;
    int dones;
    logic [DW-1:0] v [$];

    i_arst_n = 1'b0; i_start = 1'b0; i_src_addr = '0; i_dst_addr = '0; i_length = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge i_clk);
    lit("reset_outputs", all_outputs(), 80'(0));
    #1 i_arst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Basic 4-word copy.
    v = '{32'h11, 32'h22, 32'h33, 32'h44};
    preload(0, v);
    start_req(0, 16, 4);
    wait_done(cyc, wes, consec, ferr);
    lit("t1_done_cycle", 80'(cyc), 80'(9));
    lit("t1_we_count", 80'(wes), 80'(4));
    lit("t1_we_alternate", 80'(consec), 80'(0));
    lit("t1_words", 80'(o_words_copied), 80'(4));
    lit("t1_error", 80'(o_error), 80'(0));
    lit("t1_dst", 80'({mem[16], mem[17]}), 80'({32'h11, 32'h22}));
    lit("t1_dst_hi", 80'({mem[18], mem[19]}), 80'({32'h33, 32'h44}));
    lit("t1_src", 80'({mem[0], mem[3]}), 80'({32'h11, 32'h44}));
    image_check("t1_image");

    // Zero length.
    start_req(5, 9, 0);
    wait_done(cyc, wes, consec, ferr);
    lit("t2_done_cycle", 80'(cyc), 80'(1));
    lit("t2_we_count", 80'(wes), 80'(0));
    lit("t2_words_err", 80'({o_words_copied, o_error}), 80'(0));

    // Range violation, then a valid request clears the error.
    start_req(126, 0, 4);
    wait_done(cyc, wes, consec, ferr);
    lit("t3_done_cycle", 80'(cyc), 80'(1));
    lit("t3_we_count", 80'(wes), 80'(0));
    repeat (3) @(negedge i_clk);
    lit("t3_error_held", 80'(o_error), 80'(1));
    image_check("t3_image");
    start_req(10, 20, 1);
    wait_done(cyc, wes, consec, ferr);
    lit("t3_error_cleared", 80'(ferr), 80'(0));
    lit("t3_len1_done_cycle", 80'(cyc), 80'(3));
    lit("t3_len1_data", 80'(mem[20]), 80'(32'hC0DE000A));

    // Start pulse while busy is ignored.
    start_req(0, 32, 4);
    dones = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge i_clk);
      if (o_done) dones++;
      if (n == 2) begin
        #1 i_start = 1'b1; i_src_addr = 50; i_dst_addr = 60; i_length = 2;
      end
      if (n == 4) begin
        #1 i_start = 1'b0;
      end
    end
    lit("t4_done_pulses", 80'(dones), 80'(1));
    lit("t4_ignored_dst", 80'(mem[60]), 80'(32'hC0DE003C));
    lit("t4_copy", 80'({mem[32], mem[35]}), 80'({32'h11, 32'h44}));
    image_check("t4_image");

    // Overlapping ascending copy.
    v = '{32'hA5, 32'h0, 32'h0, 32'h0};
    preload(0, v);
    start_req(0, 1, 3);
    wait_done(cyc, wes, consec, ferr);
    lit("t5_done_cycle", 80'(cyc), 80'(7));
    lit("t5_overlap", 80'({mem[1], mem[2]}), 80'({32'hA5, 32'hA5}));
    lit("t5_overlap_last", 80'(mem[3]), 80'(32'hA5));
    image_check("t5_image");

    // Asynchronous reset during the third WRITE cycle.
    v = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    preload(0, v);
    start_req(0, 40, 8);
    repeat (5) @(posedge i_clk);
    #2;
    lit("t6_we_before_reset", 80'(o_mem_we), 80'(1));
    i_arst_n = 1'b0;
    #1;
    lit("t6_we_async_drop", 80'(o_mem_we), 80'(0));
    lit("t6_outputs_in_reset", all_outputs(), 80'(0));
    repeat (2) @(negedge i_clk);
    lit("t6_outputs_held_reset", all_outputs(), 80'(0));
    #1 i_arst_n = 1'b1;
    lit("t6_written", 80'({mem[40], mem[41]}), 80'({32'h1, 32'h2}));
    for (int i = 42; i < 48; i++)
      lit($sformatf("t6_untouched_%0d", i), 80'(mem[i]), 80'(32'hC0DE0000 | 32'(i)));
    image_check("t6_image");
    repeat (2) @(negedge i_clk);
    start_req(2, 50, 2);
    wait_done(cyc, wes, consec, ferr);
    lit("t6_restart_done_cycle", 80'(cyc), 80'(5));
    lit("t6_restart_data", 80'({mem[50], mem[51]}), 80'({32'h3, 32'h4}));
    image_check("t6_final_image");
    repeat (2) @(negedge i_clk);

    $display("%0d/%0d checks passed", (lit_checks - lit_fails) + (cmp_checks - cmp_fails),
             lit_checks + cmp_checks);
    $finish;
  end

endmodule
